// File: rtl/pid_pwm_driver.sv
// pid_pwm_driver: turns the signed PID control word into a motor PWM plus direction line.
// The word is scaled by an arithmetic right shift and its magnitude clipped to the PWM range.
// New values take effect only at period boundaries, and a direction reversal inserts a dead-time.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_un, i_valid    signed control word and its one-cycle qualifier
//   i_enable         drive enable; low forces the PWM off immediately
//   o_pwm            PWM to the power stage (gated combinationally by state and enable)
//   o_dir            0 = forward, 1 = reverse
//   o_sat            one-cycle pulse: the captured sample was clipped
//   o_overrun        one-cycle pulse: a pending sample was overwritten before use
//   o_period_start   high on the first cycle (cnt==0) of each RUN period
module pid_pwm_driver #(
  parameter int unsigned PWM_BITS    = 10,
  parameter int unsigned SAT_SHIFT   = 0,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_un,
  input  logic        i_valid,
  input  logic        i_enable,
  output logic        o_pwm,
  output logic        o_dir,
  output logic        o_sat,
  output logic        o_overrun,
  output logic        o_period_start
);

  localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = DUTY_MAX - PWM_BITS'(1);
  localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t              state, state_d;
  logic [PWM_BITS-1:0] cnt, duty;
  logic [DW-1:0]       dead_cnt;
  logic                dir, sat, overrun;
  logic                pend, pend_dir, tgt_dir;
  logic [PWM_BITS-1:0] pend_mag, tgt_mag;

  // Capture path: shift, magnitude (33 bits so -2^31 is representable), clip, sign
  logic signed [31:0]  shifted;
  logic signed [32:0]  wide;
  logic [32:0]         abs_v;
  logic                clip;
  logic [PWM_BITS-1:0] cap_mag;
  logic                cap_dir;

  always_comb begin
    shifted = $signed(i_un) >>> SAT_SHIFT;
    wide    = {shifted[31], shifted};
    abs_v   = shifted[31] ? 33'(-wide) : 33'(wide);
    clip    = abs_v > 33'(DUTY_MAX);
    cap_mag = clip ? DUTY_MAX : abs_v[PWM_BITS-1:0];
    if (shifted[31])          cap_dir = 1'b1;
    else if (shifted != 32'sd0) cap_dir = 1'b0;
    else                      cap_dir = dir;
  end

  // Next-state and boundary decisions
  logic boundary, consume, reverse, dead_done;

  always_comb begin
    state_d   = state;
    boundary  = 1'b0;
    dead_done = 1'b0;
    case (state)
      IDLE: if (i_enable) boundary = 1'b1;
      RUN: begin
        if (!i_enable)            state_d  = IDLE;
        else if (cnt == CNT_LAST) boundary = 1'b1;
      end
      DEAD: begin
        if (!i_enable) state_d = IDLE;
        else if (dead_cnt == DEAD_LAST) begin
          dead_done = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered pending only: a strobe on the boundary cycle waits for the next one
    consume = boundary && pend;
    reverse = consume && (pend_dir != dir) && (pend_mag != '0);
    if (boundary) state_d = reverse ? DEAD : RUN;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      duty     <= '0;
      dir      <= 1'b0;
      dead_cnt <= '0;
      pend     <= 1'b0;
      pend_mag <= '0;
      pend_dir <= 1'b0;
      tgt_mag  <= '0;
      tgt_dir  <= 1'b0;
      sat      <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= (state == RUN && state_d == RUN && !boundary) ? cnt + PWM_BITS'(1) : '0;
      dead_cnt <= (state == DEAD) ? dead_cnt + DW'(1) : '0;

      if (consume && !reverse) duty <= pend_mag;
      else if (dead_done)      duty <= tgt_mag;

      if (dead_done) dir <= tgt_dir;

      // Reversal target is held apart so strobes during DEAD only touch pending
      if (reverse) begin
        tgt_mag <= pend_mag;
        tgt_dir <= pend_dir;
      end

      if (i_valid) begin
        pend     <= 1'b1;
        pend_mag <= cap_mag;
        pend_dir <= cap_dir;
      end else if (consume) begin
        pend <= 1'b0;
      end

      sat     <= i_valid && clip;
      overrun <= i_valid && pend && !consume;
    end
  end

  assign o_pwm          = (state == RUN) && i_enable && (cnt < duty);
  assign o_period_start = (state == RUN) && (cnt == '0);
  assign o_dir          = dir;
  assign o_sat          = sat;
  assign o_overrun      = overrun;

endmodule

// File: tb/tb_pid_pwm_driver.sv
// tb_pid_pwm_driver: random and directed stimulus for pid_pwm_driver (PWM_BITS=4, DEAD_CYCLES=2).
// A per-cycle reference model pushes expected outputs to a scoreboard queue; a monitor pops and compares.
module tb_pid_pwm_driver;

  localparam int PWM_BITS = 4;
  localparam int SHIFT    = 0;
  localparam int DEADC    = 2;
  localparam int PERIOD   = (1 << PWM_BITS) - 1;
  localparam int DMAX     = (1 << PWM_BITS) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_un = '0;
  logic        i_valid = 1'b0;
  logic        i_enable = 1'b0;
  logic        o_pwm, o_dir, o_sat, o_overrun, o_period_start;

  pid_pwm_driver #(.PWM_BITS(PWM_BITS), .SAT_SHIFT(SHIFT), .DEAD_CYCLES(DEADC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_un(i_un), .i_valid(i_valid), .i_enable(i_enable),
    .o_pwm(o_pwm), .o_dir(o_dir), .o_sat(o_sat), .o_overrun(o_overrun),
    .o_period_start(o_period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pwm;
    logic dir;
    logic sat;
    logic ovr;
    logic ps;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: mode 0 idle, 1 run, 2 dead; position within period, dead clocks remaining
  int  m_mode, m_pos, m_duty, m_pmag, m_tmag, m_dead_left;
  bit  m_dir, m_pend, m_pdir, m_tdir, m_sat, m_ovr;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_duty = 0; m_pmag = 0; m_tmag = 0; m_dead_left = 0;
    m_dir = 0; m_pend = 0; m_pdir = 0; m_tdir = 0; m_sat = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] un, input bit en);
    exp_t   e;
    longint s, mag;
    bit     clip, rdir, bnd, cons, old_pend, old_pdir;
    int     old_pmag;
    e.pwm = (m_mode == 1) && en && (m_pos < m_duty);
    e.ps  = (m_mode == 1) && (m_pos == 0);
    e.dir = m_dir;
    e.sat = m_sat;
    e.ovr = m_ovr;
    exp_q.push_back(e);

    s    = longint'($signed(un)) >>> SHIFT;
    mag  = (s < 0) ? -s : s;
    clip = mag > DMAX;
    if (clip) mag = DMAX;
    rdir = (s < 0) ? 1'b1 : ((s > 0) ? 1'b0 : m_dir);

    old_pend = m_pend; old_pmag = m_pmag; old_pdir = m_pdir;
    bnd  = en && (m_mode == 0 || (m_mode == 1 && m_pos == PERIOD - 1));
    cons = bnd && old_pend;

    if (m_mode == 2) begin
      if (!en) m_mode = 0;
      else if (m_dead_left == 1) begin
        m_dir = m_tdir; m_duty = m_tmag; m_mode = 1; m_pos = 0;
      end else m_dead_left--;
    end else if (!en) begin
      m_mode = 0; m_pos = 0;
    end else if (bnd) begin
      m_pos = 0;
      if (cons && old_pdir != m_dir && old_pmag != 0) begin
        m_mode = 2; m_dead_left = DEADC; m_tmag = old_pmag; m_tdir = old_pdir;
      end else begin
        if (cons) m_duty = old_pmag;
        m_mode = 1;
      end
    end else m_pos++;

    if (v) begin
      m_pend = 1; m_pmag = int'(mag); m_pdir = rdir;
    end else if (cons) m_pend = 0;

    m_sat = v && clip;
    m_ovr = v && old_pend && !cons;
  endtask

  // Monitor: one expected entry per cycle, sampled well after the input change
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("o_pwm", o_pwm, e.pwm);
        check("o_dir", o_dir, e.dir);
        check("o_sat", o_sat, e.sat);
        check("o_overrun", o_overrun, e.ovr);
        check("o_period_start", o_period_start, e.ps);
      end
    end
  end

  task automatic cycle(input bit v, input logic [31:0] un, input bit en, input bit rst,
                       output bit p, output bit ps, output bit d);
    @(negedge clk);
    if (rst) begin
      rst_n = 1'b0; i_valid = 1'b0;
      model_reset();
      exp_q.push_back('0);
    end else begin
      rst_n = 1'b1; i_valid = v; i_un = un; i_enable = en;
      model_step(v, un, en);
    end
    #2;
    p = o_pwm; ps = o_period_start; d = o_dir;
  endtask

  task automatic strobe(input logic [31:0] un);
    bit p, ps, d;
    cycle(1'b1, un, 1'b1, 1'b0, p, ps, d);
  endtask

  task automatic idle(input int n);
    bit p, ps, d;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, p, ps, d);
  endtask

  // Step until the next driven cycle lands on period position pos
  task automatic align(input int pos);
    bit p, ps, d, hit;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, p, ps, d);
      hit = (m_mode == 1) && (m_pos == pos);
    end
    if (!hit) check("align timeout", 0, 1);
  endtask

  // Count PWM-high clocks over one full period starting at o_period_start
  task automatic measure(input int exp_high, input bit exp_dir, input string nm);
    bit p, ps, d, seen;
    int highs;
    seen = 0;
    highs = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, p, ps, d);
      seen = ps;
    end
    if (!seen) check({nm, " period_start timeout"}, 0, 1);
    else begin
      highs = int'(p);
      for (int i = 1; i < PERIOD; i++) begin
        cycle(1'b0, '0, 1'b1, 1'b0, p, ps, d);
        highs += int'(p);
      end
      check({nm, " high clocks"}, highs, exp_high);
      check({nm, " dir"}, d, exp_dir);
    end
  endtask

  initial begin
    bit p, ps, d, en_r, v, rst;
    logic [31:0] un;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, p, ps, d);

    strobe(32'd5);
    idle(20);
    measure(5, 1'b0, "duty5 fwd");

    strobe(32'd1000);
    idle(40);
    measure(15, 1'b0, "clip fwd");
    strobe(-32'sd16);
    idle(45);
    measure(15, 1'b1, "clip rev");

    strobe(32'd5);
    idle(45);
    measure(5, 1'b0, "rev to fwd 5");
    strobe(-32'sd3);
    idle(45);
    measure(3, 1'b1, "fwd to rev 3");

    align(2);
    strobe(32'd4);
    idle(1);
    strobe(32'd9);
    idle(40);
    measure(9, 1'b0, "overrun newest");

    align(PERIOD - 1);
    strobe(32'd7);
    measure(9, 1'b0, "boundary strobe deferred");
    measure(7, 1'b0, "boundary strobe applied");

    strobe(-32'sd6);
    idle(45);
    strobe(32'd0);
    idle(40);
    measure(0, 1'b1, "zero keeps dir");

    strobe(32'd7);
    idle(60);
    align(1);
    cycle(1'b0, '0, 1'b1, 1'b1, p, ps, d);
    check("reset drops pwm", p, 0);

    en_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) en_r = !en_r;
      rst = ($urandom_range(0, 1499) == 0);
      v   = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0:       un = 32'(int'($urandom_range(0, 40)) - 20);
        1:       un = $urandom;
        2:       un = '0;
        3:       un = 32'h8000_0000;
        default: un = 32'($urandom_range(1, 15));
      endcase
      cycle(v, un, en_r, rst, p, ps, d);
    end

    idle(2);
    @(negedge clk);
    #3;
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
